// File: rtl/matvec_result_packer.sv
// Collects one matrix-vector result stream into a row buffer and drains it as
// BANDWIDTH-wide chunks over valid/ready. Optional bias add: MATVEC_PACKER_BIAS_ADD_EN.
module matvec_result_packer #(
  parameter int MAX_ROWS   = 64,
  parameter int BANDWIDTH  = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [$clog2(MAX_ROWS+1)-1:0] num_rows,
  input  logic [DATA_WIDTH-1:0]         result_in,
  input  logic                          result_valid,
  input  logic                          bias_write_enable,
  input  logic [$clog2(MAX_ROWS)-1:0]   bias_base_addr,
  input  logic [DATA_WIDTH-1:0]         bias_in [0:BANDWIDTH-1],
  output logic [DATA_WIDTH-1:0]         out_data [0:BANDWIDTH-1],
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
);

  localparam int NRW    = $clog2(MAX_ROWS + 1);
  localparam int AW     = $clog2(MAX_ROWS);
  localparam int NCHUNK = (MAX_ROWS + BANDWIDTH - 1) / BANDWIDTH;
  localparam int CW     = $clog2(NCHUNK + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;

  localparam logic [NRW-1:0]        MAX_ROWS_N = NRW'(MAX_ROWS);
  localparam logic [DATA_WIDTH-1:0] SAT_MAX    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]            state_reg;
  logic [NRW-1:0]        rows_reg;
  logic [NRW-1:0]        row_idx_reg;
  logic [CW-1:0]         chunk_reg;
  logic                  done_reg;
  logic                  overflow_reg;
  logic [DATA_WIDTH-1:0] row_buf [MAX_ROWS];

  logic [NRW-1:0]        rows_clamped;
  logic [AW-1:0]         row_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  last_chunk;

  assign rows_clamped = (num_rows > MAX_ROWS_N) ? MAX_ROWS_N : num_rows;
  assign row_addr     = row_idx_reg[AW-1:0];
  assign last_chunk   = ((int'(chunk_reg) + 1) * BANDWIDTH) >= int'(rows_reg);

`ifdef MATVEC_PACKER_BIAS_ADD_EN
  logic [DATA_WIDTH-1:0] bias_mem [MAX_ROWS];
  logic [DATA_WIDTH-1:0] bias_rd;
  logic [DATA_WIDTH:0]   sum_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < MAX_ROWS; r++) bias_mem[r] <= '0;
    end else if (state_reg == S_IDLE && bias_write_enable) begin
      // Lanes whose address lands at or past MAX_ROWS simply match no row.
      for (int r = 0; r < MAX_ROWS; r++)
        for (int j = 0; j < BANDWIDTH; j++)
          if (int'(bias_base_addr) + j == r) bias_mem[r] <= bias_in[j];
    end
  end

  assign bias_rd = bias_mem[row_addr];
  assign sum_ext = {result_in[DATA_WIDTH-1], result_in} + {bias_rd[DATA_WIDTH-1], bias_rd};

  always_comb begin
    wr_data = sum_ext[DATA_WIDTH-1:0];
    if (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1])
      wr_data = sum_ext[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
  end
`else
  logic unused_bias;

  always_comb begin
    unused_bias = bias_write_enable ^ (^bias_base_addr) ^ (^SAT_MAX) ^ (^SAT_MIN);
    for (int j = 0; j < BANDWIDTH; j++) unused_bias = unused_bias ^ (^bias_in[j]);
  end

  assign wr_data = result_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < MAX_ROWS; r++) row_buf[r] <= '0;
    end else if (state_reg == S_COLLECT && result_valid) begin
      row_buf[row_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      rows_reg     <= '0;
      row_idx_reg  <= '0;
      chunk_reg    <= '0;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start && num_rows != '0) begin
            state_reg    <= S_COLLECT;
            rows_reg     <= rows_clamped;
            row_idx_reg  <= '0;
            chunk_reg    <= '0;
            // A result coinciding with the start is stray: clear, then flag it.
            overflow_reg <= result_valid;
          end else if (result_valid) begin
            overflow_reg <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (result_valid) begin
            row_idx_reg <= row_idx_reg + 1'b1;
            if (row_idx_reg == rows_reg - 1'b1) begin
              state_reg <= S_DRAIN;
              chunk_reg <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (result_valid) overflow_reg <= 1'b1;
          if (out_ready) begin
            if (last_chunk) begin
              state_reg <= S_IDLE;
              done_reg  <= 1'b1;
            end else begin
              chunk_reg <= chunk_reg + 1'b1;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Lane data is a pure function of chunk_reg and the frozen buffer, so it
  // holds steady under backpressure without a separate output register.
  genvar gi;
  generate
    for (gi = 0; gi < BANDWIDTH; gi++) begin : g_lane
      logic [31:0] lane_idx;
      assign lane_idx = 32'(chunk_reg) * BANDWIDTH + gi;
      assign out_data[gi] = (state_reg == S_DRAIN && lane_idx < 32'(rows_reg))
                            ? row_buf[lane_idx[AW-1:0]] : '0;
    end
  endgenerate

  assign out_valid = (state_reg == S_DRAIN);
  assign out_last  = (state_reg == S_DRAIN) && last_chunk;
  assign busy      = (state_reg != S_IDLE);
  assign done      = done_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_matvec_result_packer.sv
// Scoreboard bench for matvec_result_packer (MAX_ROWS=8, BANDWIDTH=4); bias
// expectations follow MATVEC_PACKER_BIAS_ADD_EN.
module tb_matvec_result_packer;
  localparam int MR = 8;
  localparam int BW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    num_rows = '0;
  logic [DW-1:0] result_in = '0;
  logic          result_valid = 1'b0;
  logic          bias_write_enable = 1'b0;
  logic [2:0]    bias_base_addr = '0;
  logic [DW-1:0] bias_in [0:BW-1];
  logic [DW-1:0] out_data [0:BW-1];
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          overflow;

  matvec_result_packer #(.MAX_ROWS(MR), .BANDWIDTH(BW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows),
    .result_in(result_in), .result_valid(result_valid),
    .bias_write_enable(bias_write_enable), .bias_base_addr(bias_base_addr),
    .bias_in(bias_in), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d [BW];
    int last;
  } chunk_t;

  chunk_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int vec [MR];
  int bias_model [MR];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic void push_exp(input int n);
    int ne;
    chunk_t c;
    ne = (n > MR) ? MR : n;
    for (int ci = 0; ci * BW < ne; ci++) begin
      for (int k = 0; k < BW; k++)
        c.d[k] = (ci * BW + k < ne) ? sat(vec[ci * BW + k] + bias_model[ci * BW + k]) : 0;
      c.last = ((ci + 1) * BW >= ne) ? 1 : 0;
      exp_q.push_back(c);
    end
  endfunction

  // Monitor: every presented chunk is checked against the queue head; pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_chunk: got out_valid=1 lane0=%0d required no chunk pending",
                   $signed(out_data[0]));
        end else begin
          for (int k = 0; k < BW; k++)
            chk($sformatf("lane%0d", k), int'($signed(out_data[k])), exp_q[0].d[k]);
          chk("out_last", int'(out_last), exp_q[0].last);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    num_rows = 4'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int v);
    result_valid = 1'b1;
    result_in = 16'(v);
    tick();
    result_valid = 1'b0;
  endtask

  task automatic run_collect(input int n);
    int ne;
    ne = (n > MR) ? MR : n;
    do_start(n);
    chk("busy_collect", int'(busy), 1);
    for (int i = 0; i < ne; i++) begin
      if (i == ne - 1) chk("valid_before_last", int'(out_valid), 0);
      send(vec[i]);
    end
    push_exp(n);
    chk("valid_latency", int'(out_valid), 1);
  endtask

  task automatic wait_done(input int max_cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < max_cycles && seen == 0; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_pulse", seen, 1);
    chk("idle_after_done", int'(busy), 0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", int'(done), 0);
  endtask

  task automatic bias_write(input int base, input int b0, input int b1, input int b2,
                            input int b3, input int accept);
    int bv [BW];
    bv[0] = b0; bv[1] = b1; bv[2] = b2; bv[3] = b3;
    bias_base_addr = 3'(base);
    for (int j = 0; j < BW; j++) bias_in[j] = 16'(bv[j]);
    bias_write_enable = 1'b1;
    tick();
    bias_write_enable = 1'b0;
`ifdef MATVEC_PACKER_BIAS_ADD_EN
    if (accept != 0)
      for (int j = 0; j < BW; j++) if (base + j < MR) bias_model[base + j] = bv[j];
`else
    if (accept != 0) bias_base_addr = '0;
`endif
  endtask

  task automatic set_vec(input int a0, input int a1, input int a2, input int a3,
                         input int a4, input int a5, input int a6, input int a7);
    vec[0] = a0; vec[1] = a1; vec[2] = a2; vec[3] = a3;
    vec[4] = a4; vec[5] = a5; vec[6] = a6; vec[7] = a7;
  endtask

  initial begin
    for (int j = 0; j < BW; j++) bias_in[j] = '0;
    for (int r = 0; r < MR; r++) bias_model[r] = 0;

    // Reset state
    #3;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_lane0", int'(out_data[0]), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Single full chunk
    set_vec(4096, 8192, -4096, 0, 0, 0, 0, 0);
    run_collect(4);
    wait_done(20);

    // Backpressure with start and a stray result during DRAIN
    out_ready = 1'b0;
    set_vec(100, 200, 300, 400, 500, 600, 0, 0);
    run_collect(6);
    start = 1'b1;
    num_rows = 4'd1;
    result_valid = 1'b1;
    result_in = 16'd777;
    tick();
    start = 1'b0;
    result_valid = 1'b0;
    repeat (4) tick();
    chk("overflow_drain", int'(overflow), 1);
    chk("busy_drain", int'(busy), 1);
    out_ready = 1'b1;
    wait_done(20);
    chk("overflow_sticky", int'(overflow), 1);

    // Accepted start clears overflow
    set_vec(-5, 7, 0, 0, 0, 0, 0, 0);
    run_collect(2);
    chk("overflow_cleared", int'(overflow), 0);
    wait_done(20);

    // Stray result in IDLE, then one on the start cycle
    result_valid = 1'b1;
    result_in = 16'd1234;
    tick();
    result_valid = 1'b0;
    chk("overflow_idle", int'(overflow), 1);
    start = 1'b1;
    num_rows = 4'd3;
    result_valid = 1'b1;
    result_in = 16'd999;
    tick();
    start = 1'b0;
    result_valid = 1'b0;
    chk("overflow_start_cycle", int'(overflow), 1);
    set_vec(11, 22, 33, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) send(vec[i]);
    push_exp(3);
    wait_done(20);

    // Zero-row start is ignored
    do_start(0);
    chk("zero_rows_busy", int'(busy), 0);
    tick();
    chk("zero_rows_done", int'(done), 0);

    // Reset mid-operation
    do_start(4);
    send(111);
    send(222);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_overflow", int'(overflow), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_done", int'(done), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    set_vec(1000, 2000, 3000, 4000, 0, 0, 0, 0);
    run_collect(4);
    wait_done(20);

    // num_rows above MAX_ROWS clamps to MAX_ROWS
    set_vec(-1, -2, -3, -4, -5, -6, -7, -8);
    run_collect(12);
    wait_done(20);

    // Bias with saturation; a write during COLLECT is ignored
    bias_write(0, 4096, 32767, -32768, 0, 1);
    set_vec(4096, 4096, -4096, 100, 0, 0, 0, 0);
    do_start(4);
    bias_write(0, 1, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) send(vec[i]);
    push_exp(4);
    wait_done(20);

    set_vec(0, 0, 0, 0, 0, 0, 0, 0);
    run_collect(4);
    wait_done(20);

    // Lanes past MAX_ROWS are discarded, not wrapped
    bias_write(6, 10, 20, 30, 40, 1);
    run_collect(8);
    wait_done(20);

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matvec_result_packer.md
Name: matvec_result_packer

Overview:
- Downstream stage of matvec_multiplier.
- Captures the scalar per-row stream (result_out/result_valid) for one matrix-vector operation into a local row buffer.
- Optionally adds a per-row bias with Q4.12 saturation.
- Drains the finished vector in BANDWIDTH-wide chunks over a valid/ready interface to the next LSTM stage, absorbing backpressure that matvec_multiplier cannot.

Parameters:
- MAX_ROWS, 64: maximum rows per operation; sets buffer depth.
- BANDWIDTH, 4: lanes per output chunk and per bias write.
- DATA_WIDTH, 16: signed Q4.12 element width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins collection; sampled only in IDLE.
- num_rows  input  $clog2(MAX_ROWS+1)  rows expected; latched on accepted start.
- result_in  input  DATA_WIDTH  signed row result from matvec_multiplier.
- result_valid  input  1  result_in valid this cycle.
- bias_write_enable  input  1  write BANDWIDTH bias values.
- bias_base_addr  input  $clog2(MAX_ROWS)  first row index of the bias write.
- bias_in[0:BANDWIDTH-1]  input  DATA_WIDTH each  signed Q4.12 bias values.
- out_data[0:BANDWIDTH-1]  output  DATA_WIDTH each  current output chunk.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts the chunk.
- out_last  output  1  current chunk is the final one of the vector.
- busy  output  1  high in COLLECT or DRAIN.
- done  output  1  one-cycle pulse after the final chunk handshake.
- overflow  output  1  sticky; a result arrived when none was expected.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - out_valid, out_last, busy, done, overflow = 0; out_data lanes = 0.
  - Row index and chunk index = 0.
  - Row buffer and bias memory cleared to 0.
  - Reset asserted mid-operation aborts it; no partial output is emitted.
- States:
  - IDLE -> COLLECT on start with num_rows != 0.
    - Latch num_rows, clear row index, clear overflow.
    - start with num_rows = 0 is ignored; no done pulse.
  - COLLECT: each result_valid cycle writes buf[row_idx] = sat(result_in + bias[row_idx]), then row_idx++.
    - When the write of row num_rows-1 occurs, go to DRAIN next cycle.
    - out_valid is first high the cycle after that last accept (latency 1).
  - DRAIN: out_valid=1.
    - Lane k of out_data = buf[chunk*BANDWIDTH + k] if that index < num_rows, else 0.
    - out_last=1 when (chunk+1)*BANDWIDTH >= num_rows.
    - out_valid && out_ready: chunk++. On the last chunk, go to IDLE instead and pulse done the following cycle.
    - out_data and out_last stay stable while out_valid && !out_ready.
- Saturation: sum computed at DATA_WIDTH+1 bits, clamped to [-32768, 32767].
- Boundary conditions:
  - start while busy: ignored.
  - result_valid in IDLE or DRAIN: dropped, overflow set. overflow clears only on an accepted start or reset.
  - result_valid on the same cycle as an accepted start: dropped, overflow set after the clear, so it reads 1.
  - Bias writes:
    - Accepted only in IDLE; ignored otherwise.
    - Lane j writes bias[bias_base_addr+j]; lanes at or beyond MAX_ROWS are discarded.
  - num_rows > MAX_ROWS: treated as MAX_ROWS.
  - out_ready high outside DRAIN: no effect.

Optional Feature:
- Macro: MATVEC_PACKER_BIAS_ADD_EN.
- Defined: bias memory and saturating adder present, as described above.
- Undefined:
  - No bias memory or adder; buf[row] = result_in unchanged.
  - Bias ports remain in the port list but are ignored.
  - Reads as zero bias, so no saturation is possible.

Test Plan:
- MAX_ROWS=4, BANDWIDTH=4, no bias. Start num_rows=4; results 4096, 8192, -4096, 0 on consecutive cycles -> one chunk {4096, 8192, -4096, 0}, out_last=1, out_valid exactly 1 cycle after the 4th result, done pulse after the handshake.
- Backpressure: MAX_ROWS=8, num_rows=6, out_ready low 5 cycles -> chunk0 {r0..r3} held stable; then chunk1 {r4, r5, 0, 0} with out_last=1.
- Bias (macro on): bias {4096, 32767, -32768, 0}, results {4096, 4096, -4096, 100} -> {8192, 32767, -32768, 100}.
- Bias write attempted during COLLECT -> ignored; next operation uses the old bias.
- Stray results: result_valid in IDLE -> overflow=1; then a new start -> overflow=0 and normal output.
- Reset mid-operation: rst_n low after 2 of 4 results -> all outputs 0 immediately. Next full operation is correct with no stale rows.
